uart_tx_serializer: RTL and testbench

UART transmit serializer that drains the UART's byte FIFO and drives the serial TX line. It pops bytes from the read side of the synchronous first-word-fall-through FIFO and emits each byte as one asynchronous frame: start bit, 8 data bits LSB-first, optional parity, 1 or 2 stop bits. Bit timing comes from a runtime divisor, and back-to-back bytes are sent with no idle gap.

---
 rtl/uart_tx_serializer.sv | 193 +++++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//
// Drains a synchronous first-word-fall-through byte FIFO and serializes each
// byte onto the UART TX line as one asynchronous frame:
//   start bit (0), 8 data bits LSB-first, optional parity, 1 or 2 stop bits (1).
// Bit period is (divisor + 1) clock cycles. The divisor and framing options are
// captured when a byte is popped, so they stay fixed for the whole frame.
// The next byte is popped in the last cycle of the previous frame's final stop
// bit, so back-to-back frames have no idle gap.
//
// Ports:
//   i_clk         clock
//   i_reset       synchronous, active-high reset
//   i_enable      permits popping a new byte (never aborts a frame)
//   i_divisor     bit period minus one, in i_clk cycles
//   i_parity_en   append a parity bit
//   i_parity_odd  1 = odd parity, 0 = even parity
//   i_two_stop    1 = two stop bits
//   i_fifo_empty  FIFO empty flag
//   i_fifo_data   FIFO head byte, valid while not empty
//   o_fifo_rd     pop strobe (combinational), FIFO advances on this edge
//   o_tx          serial output, idle high (registered)
//   o_busy        frame in progress (registered)
//   o_done        one-cycle pulse in the final cycle of the last stop bit
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int DW    = 8,
    parameter int DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic [DIV_W-1:0] i_divisor,
    input  logic             i_parity_en,
    input  logic             i_parity_odd,
    input  logic             i_two_stop,
    input  logic             i_fifo_empty,
    input  logic [DW-1:0]    i_fifo_data,
    output logic             o_fifo_rd,
    output logic             o_tx,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Control state (reset)
    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Per-frame datapath (no reset needed)
    logic [DW-1:0]    shreg_q, shreg_d;
    logic [DW-1:0]    byte_q, byte_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             par_en_q, par_en_d;
    logic             par_odd_q, par_odd_d;
    logic             two_stop_q, two_stop_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             stop_idx_q, stop_idx_d;

    logic             bit_end;
    logic             last_stop;
    logic             pop;
    logic             parity_d;

    assign bit_end   = (cnt_q == div_q);
    // Final cycle of the final stop bit: stop_idx reaches 1 only with two stop bits.
    assign last_stop = (state_q == S_STOP) && bit_end && (stop_idx_q == two_stop_q);
    assign pop       = i_enable & ~i_fifo_empty & ~i_reset &
                       ((state_q == S_IDLE) | last_stop);
    assign o_fifo_rd = pop;

    // Next-state logic
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        cnt_d      = (state_q == S_IDLE || bit_end) ? '0 : cnt_q + DIV_W'(1);
        shreg_d    = shreg_q;
        byte_d     = byte_q;
        div_d      = div_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        two_stop_d = two_stop_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;

        case (state_q)
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shreg_d   = shreg_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d    = par_en_q ? S_PARITY : S_STOP;
                        stop_idx_d = 1'b0;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d    = S_STOP;
                    stop_idx_d = 1'b0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (stop_idx_q == two_stop_q) begin
                        state_d = S_IDLE;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // A pop (from IDLE or the last stop cycle) starts a fresh frame and
        // captures the byte plus all framing options for its whole duration.
        if (pop) begin
            state_d    = S_START;
            cnt_d      = '0;
            shreg_d    = i_fifo_data;
            byte_d     = i_fifo_data;
            div_d      = i_divisor;
            par_en_d   = i_parity_en;
            par_odd_d  = i_parity_odd;
            two_stop_d = i_two_stop;
        end
    end

    // Outputs are decoded from the next state and registered, so o_tx,
    // o_busy and o_done carry no combinational path from the inputs.
    always_comb begin
        parity_d = (^byte_d) ^ par_odd_d;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shreg_d[0];
            S_PARITY: tx_d = parity_d;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_STOP) && (cnt_d == div_d) && (stop_idx_d == two_stop_d);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // NOTE: datapath registers are not reset; they are always loaded by a pop before being used.
    always_ff @(posedge i_clk) begin
        shreg_q    <= shreg_d;
        byte_q     <= byte_d;
        div_q      <= div_d;
        par_en_q   <= par_en_d;
        par_odd_q  <= par_odd_d;
        two_stop_q <= two_stop_d;
        bit_idx_q  <= bit_idx_d;
        stop_idx_q <= stop_idx_d;
    end

    assign o_tx   = tx_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_serializer
//
// Directed bench for uart_tx_serializer. A small array FIFO feeds the DUT.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling
// edge. Expected line levels are built from the byte and framing options.
// -----------------------------------------------------------------------------
module tb_uart_tx_serializer;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic [15:0] i_divisor;
    logic        i_parity_en;
    logic        i_parity_odd;
    logic        i_two_stop;
    logic        i_fifo_empty;
    logic [7:0]  i_fifo_data;
    logic        o_fifo_rd;
    logic        o_tx;
    logic        o_busy;
    logic        o_done;

    int tests_run    = 0;
    int tests_failed = 0;

    // Simple FIFO model: pushed from the stimulus, popped on o_fifo_rd.
    logic [7:0] fifo_mem [16];
    int         wr_ptr = 0;
    int         rd_ptr = 0;

    assign i_fifo_empty = (wr_ptr == rd_ptr);
    assign i_fifo_data  = fifo_mem[rd_ptr % 16];

    always @(posedge i_clk) begin
        if (o_fifo_rd) rd_ptr <= rd_ptr + 1;
    end

    always #5 i_clk = ~i_clk;

    uart_tx_serializer #(.DW(8), .DIV_W(16)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_enable     (i_enable),
        .i_divisor    (i_divisor),
        .i_parity_en  (i_parity_en),
        .i_parity_odd (i_parity_odd),
        .i_two_stop   (i_two_stop),
        .i_fifo_empty (i_fifo_empty),
        .i_fifo_data  (i_fifo_data),
        .o_fifo_rd    (o_fifo_rd),
        .o_tx         (o_tx),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    task automatic check(input string tag, input logic got, input logic exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Move to just after the next rising edge (input drive point).
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Move to the falling edge (output sample point).
    task automatic settle();
        @(negedge i_clk);
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr % 16] = b;
        wr_ptr++;
    endtask

    task automatic expect_idle(input string tag);
        step();
        settle();
        check({tag, "_tx"},   o_tx,      1'b1);
        check({tag, "_busy"}, o_busy,    1'b0);
        check({tag, "_done"}, o_done,    1'b0);
        check({tag, "_rd"},   o_fifo_rd, 1'b0);
    endtask

    // Called at the sample point of the pop cycle. Walks the whole frame,
    // checking every cycle. Optional mid-frame actions: drop i_enable or
    // change i_divisor at a given frame cycle.
    task automatic expect_frame(input logic [7:0] b, input int div, input bit pe,
                                input bit po, input bit ts, input bit next_pop,
                                input int drop_en_at, input int chg_at,
                                input logic [15:0] chg_div, input string tag);
        logic bits [12];
        int   nbits;
        int   total;
        logic last;
        nbits = 0;
        bits[nbits++] = 1'b0;
        for (int i = 0; i < 8; i++) bits[nbits++] = b[i];
        if (pe) bits[nbits++] = po ? ~(^b) : (^b);
        bits[nbits++] = 1'b1;
        if (ts) bits[nbits++] = 1'b1;
        total = nbits * (div + 1);
        for (int c = 0; c < total; c++) begin
            step();
            if (c == drop_en_at) i_enable = 1'b0;
            if (c == chg_at) i_divisor = chg_div;
            settle();
            last = (c == total - 1);
            check($sformatf("%s_tx_c%0d", tag, c),   o_tx,      bits[c / (div + 1)]);
            check($sformatf("%s_busy_c%0d", tag, c), o_busy,    1'b1);
            check($sformatf("%s_done_c%0d", tag, c), o_done,    last);
            check($sformatf("%s_rd_c%0d", tag, c),   o_fifo_rd, last & next_pop);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        logic seen_rd;
        logic seen_low;
        logic [7:0] b81;

        i_reset      = 1'b1;
        i_enable     = 1'b0;
        i_divisor    = 16'd3;
        i_parity_en  = 1'b0;
        i_parity_odd = 1'b0;
        i_two_stop   = 1'b0;

        // Reset state
        repeat (3) step();
        settle();
        check("rst_hold_tx", o_tx, 1'b1);
        step();
        i_reset = 1'b0;
        settle();
        check("rst_tx",   o_tx,      1'b1);
        check("rst_busy", o_busy,    1'b0);
        check("rst_done", o_done,    1'b0);
        check("rst_rd",   o_fifo_rd, 1'b0);

        // 1: single byte 8N1, div 3
        step();
        i_enable = 1'b1;
        push(8'h55);
        settle();
        check("t1_pop", o_fifo_rd, 1'b1);
        expect_frame(8'h55, 3, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, 16'd0, "t1");
        expect_idle("t1_after");

        // 2: odd parity, div 1, byte 0x07 -> parity bit 0
        step();
        i_divisor    = 16'd1;
        i_parity_en  = 1'b1;
        i_parity_odd = 1'b1;
        push(8'h07);
        settle();
        check("t2_pop", o_fifo_rd, 1'b1);
        expect_frame(8'h07, 1, 1'b1, 1'b1, 1'b0, 1'b0, -1, -1, 16'd0, "t2");
        expect_idle("t2_after");

        // 3: back-to-back, div 0, two stop bits
        step();
        i_divisor    = 16'd0;
        i_parity_en  = 1'b0;
        i_parity_odd = 1'b0;
        i_two_stop   = 1'b1;
        push(8'hA5);
        push(8'h3C);
        settle();
        check("t3_pop1", o_fifo_rd, 1'b1);
        expect_frame(8'hA5, 0, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1, 16'd0, "t3a");
        expect_frame(8'h3C, 0, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1, 16'd0, "t3b");
        expect_idle("t3_after");

        // 4: empty FIFO with enable high, then disable during the start bit
        step();
        i_divisor  = 16'd1;
        i_two_stop = 1'b0;
        seen_rd  = 1'b0;
        seen_low = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            settle();
            seen_rd  = seen_rd | o_fifo_rd;
            seen_low = seen_low | ~o_tx;
        end
        check("t4_empty_rd",  seen_rd,  1'b0);
        check("t4_empty_low", seen_low, 1'b0);
        step();
        push(8'hFF);
        push(8'h00);
        settle();
        check("t4_pop", o_fifo_rd, 1'b1);
        expect_frame(8'hFF, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, 16'd0, "t4");
        seen_rd = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            settle();
            seen_rd = seen_rd | o_fifo_rd;
        end
        check("t4_disabled_rd", seen_rd, 1'b0);
        check("t4_disabled_busy", o_busy, 1'b0);
        // Re-enable: the queued 0x00 goes out with div 2.
        step();
        i_divisor = 16'd2;
        i_enable  = 1'b1;
        settle();
        check("t4_reen_pop", o_fifo_rd, 1'b1);
        expect_frame(8'h00, 2, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, 16'd0, "t4z");
        expect_idle("t4_after");

        // 5: reset in DATA bit 3 of 0x81 (div 2), 0x5A queued behind it
        step();
        push(8'h81);
        push(8'h5A);
        settle();
        check("t5_pop", o_fifo_rd, 1'b1);
        b81 = 8'h81;
        for (int k = 0; k < 13; k++) begin
            step();
            if (k == 12) i_reset = 1'b1;
            settle();
            check($sformatf("t5_tx_c%0d", k), o_tx, (k < 3) ? 1'b0 : b81[(k - 3) / 3]);
            check($sformatf("t5_busy_c%0d", k), o_busy, 1'b1);
        end
        check("t5_rd_in_reset", o_fifo_rd, 1'b0);
        step();
        settle();
        check("t5_rst_tx",   o_tx,      1'b1);
        check("t5_rst_busy", o_busy,    1'b0);
        check("t5_rst_done", o_done,    1'b0);
        check("t5_rst_rd",   o_fifo_rd, 1'b0);
        step();
        i_reset = 1'b0;
        settle();
        check("t5_repop", o_fifo_rd, 1'b1);
        expect_frame(8'h5A, 2, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, 16'd0, "t5");
        expect_idle("t5_after");

        // 6: divisor 3 -> 7 changed during DATA of the first frame
        step();
        i_divisor = 16'd3;
        push(8'h96);
        push(8'h69);
        settle();
        check("t6_pop", o_fifo_rd, 1'b1);
        expect_frame(8'h96, 3, 1'b0, 1'b0, 1'b0, 1'b1, -1, 10, 16'd7, "t6a");
        expect_frame(8'h69, 7, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, 16'd0, "t6b");
        expect_idle("t6_after");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
